// File: rtl/pc16_stack.sv
// 16-bit program counter with a DEPTH-entry return-address stack, fed by an inc16 incrementer.
// Optional PC16_WRAP_TRAP_EN: inc at 0xFFFF holds the PC and raises a sticky trap instead of wrapping.

module inc16 (
  input  logic [15:0] i_a,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + 17'd1;
endmodule

module pc16_stack #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     inc,
  output logic [15:0]              out,
  output logic [$clog2(DEPTH):0]   sp_depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     ovf_err,
  output logic                     unf_err,
  output logic                     trap
);
  localparam int SPW = $clog2(DEPTH);
  localparam logic [SPW:0] FULL_CNT = (SPW+1)'(DEPTH);

  logic [15:0]    r_pc;
  logic [SPW:0]   r_sp;
  logic           r_ovf, r_unf;
  logic [15:0]    r_stack [DEPTH];

  logic [15:0]    w_sum;
  logic           w_cout;
  logic           w_full, w_empty, w_push;
  logic [SPW-1:0] w_wr_idx, w_rd_idx;

  inc16 u_inc (.i_a(r_pc), .o_sum(w_sum), .o_cout(w_cout));

  assign w_full   = (r_sp == FULL_CNT);
  assign w_empty  = (r_sp == '0);
  assign w_wr_idx = r_sp[SPW-1:0];
  assign w_rd_idx = r_sp[SPW-1:0] - 1'b1;
  // push only when call is the winning command and there is room
  assign w_push   = !clr && !load && call && !w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VEC;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clr) begin
      r_pc  <= RESET_VEC;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (load) begin
      r_pc <= in;
    end else if (call) begin
      if (w_full) r_ovf <= 1'b1;
      else begin
        r_pc <= in;
        r_sp <= r_sp + 1'b1;
      end
    end else if (ret) begin
      if (w_empty) r_unf <= 1'b1;
      else begin
        r_pc <= r_stack[w_rd_idx];
        r_sp <= r_sp - 1'b1;
      end
    end else if (inc) begin
`ifdef PC16_WRAP_TRAP_EN
      if (!w_cout) r_pc <= w_sum;
`else
      r_pc <= w_sum;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_wr_idx] <= w_sum;
  end

`ifdef PC16_WRAP_TRAP_EN
  logic r_trap;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_trap <= 1'b0;
    else if (clr)                                       r_trap <= 1'b0;
    else if (!load && !call && !ret && inc && w_cout)   r_trap <= 1'b1;
  end
  assign trap = r_trap;
`else
  logic w_unused_cout;
  assign w_unused_cout = w_cout;
  assign trap = 1'b0;
`endif

  assign out         = r_pc;
  assign sp_depth    = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;
endmodule

// File: tb/tb_pc16_stack.sv
// Directed bench for pc16_stack (DEPTH=4): commands, priority, stack over/underflow, wrap/trap, async reset.
module tb_pc16_stack;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        clr, load, call, ret, inc;
  logic [15:0] out;
  logic [2:0]  sp_depth;
  logic        stack_full, stack_empty, ovf_err, unf_err, trap;

  int total = 0;
  int bad   = 0;

  pc16_stack #(.DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(in), .clr(clr), .load(load), .call(call),
    .ret(ret), .inc(inc), .out(out), .sp_depth(sp_depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err), .trap(trap)
  );

  always #5 clk = ~clk;

`ifdef PC16_WRAP_TRAP_EN
  localparam logic [15:0] WRAP_PC   = 16'hFFFF;
  localparam logic        WRAP_TRAP = 1'b1;
`else
  localparam logic [15:0] WRAP_PC   = 16'h0000;
  localparam logic        WRAP_TRAP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // drive one command, clock it, sample 1ns after the edge
  task automatic cmd(input logic c_clr, input logic c_ld, input logic c_call,
                     input logic c_ret, input logic c_inc, input logic [15:0] d);
    clr = c_clr; load = c_ld; call = c_call; ret = c_ret; inc = c_inc; in = d;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in = '0; clr = 0; load = 0; call = 0; ret = 0; inc = 0;
    #12;
    check("rst_out", out, 16'h0000);
    check("rst_sp", sp_depth, 3'd0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_flags", {ovf_err, unf_err, trap}, 3'b000);
    reset = 1'b0;

    cmd(0,0,0,0,1,16'h0); check("inc1", out, 16'h0001);
    cmd(0,0,0,0,1,16'h0); check("inc2", out, 16'h0002);
    cmd(0,0,0,0,1,16'h0); check("inc3", out, 16'h0003);
    check("inc_sp", sp_depth, 3'd0);
    check("inc_empty", stack_empty, 1'b1);

    cmd(0,1,0,0,0,16'h1234); check("load", out, 16'h1234);
    cmd(0,0,0,0,1,16'h0);    check("load_inc", out, 16'h1235);
    cmd(0,1,0,0,1,16'h0100); check("load_over_inc", out, 16'h0100);
    cmd(0,0,0,0,0,16'hBEEF); check("hold", out, 16'h0100);

    cmd(0,1,0,0,0,16'h0010);
    cmd(0,0,1,0,0,16'h0200); check("call1", out, 16'h0200); check("call1_sp", sp_depth, 3'd1);
    cmd(0,0,1,0,0,16'h0300); check("call2", out, 16'h0300); check("call2_sp", sp_depth, 3'd2);
    cmd(0,0,0,1,0,16'h0);    check("ret1", out, 16'h0201);  check("ret1_sp", sp_depth, 3'd1);
    cmd(0,0,0,1,0,16'h0);    check("ret2", out, 16'h0011);  check("ret2_sp", sp_depth, 3'd0);

    cmd(0,0,1,0,0,16'h1000);
    cmd(0,0,1,0,0,16'h2000);
    cmd(0,0,1,0,1,16'h3000); check("call_over_inc", out, 16'h3000);
    cmd(0,0,1,1,0,16'h4000); check("call_over_ret", out, 16'h4000);
    check("full_sp", sp_depth, 3'd4);
    check("full_flag", stack_full, 1'b1);
    check("ovf_pre", ovf_err, 1'b0);
    cmd(0,0,1,0,0,16'h5000); check("ovf_out", out, 16'h4000);
    check("ovf_sp", sp_depth, 3'd4);
    check("ovf_err", ovf_err, 1'b1);

    cmd(0,0,0,1,0,16'h0); check("pop4", out, 16'h3001);
    cmd(0,0,0,1,0,16'h0); check("pop3", out, 16'h2001);
    cmd(0,0,0,1,0,16'h0); check("pop2", out, 16'h1001);
    cmd(0,0,0,1,0,16'h0); check("pop1", out, 16'h0012);
    check("unf_pre", unf_err, 1'b0);
    cmd(0,0,0,1,0,16'h0); check("unf_out", out, 16'h0012);
    check("unf_err", unf_err, 1'b1);
    check("ovf_sticky", ovf_err, 1'b1);
    cmd(0,1,1,0,0,16'h0777); check("load_over_call", out, 16'h0777);
    check("load_over_call_sp", sp_depth, 3'd0);
    cmd(1,1,0,0,0,16'h0999); check("clr_out", out, 16'h0000);
    check("clr_flags", {ovf_err, unf_err}, 2'b00);
    check("clr_empty", stack_empty, 1'b1);

    cmd(0,1,0,0,0,16'hFFFF);
    cmd(0,0,1,0,0,16'h0050); check("call_ffff", out, 16'h0050);
    cmd(0,0,0,1,0,16'h0);    check("push_wrap", out, 16'h0000);

    cmd(0,1,0,0,0,16'hFFFF);
    cmd(0,0,0,0,1,16'h0); check("wrap_out", out, WRAP_PC);
    check("wrap_trap", trap, WRAP_TRAP);
    cmd(0,0,0,0,1,16'h0); check("wrap_out2", out, WRAP_PC + ((WRAP_PC == 16'h0) ? 16'h1 : 16'h0));
    check("wrap_trap2", trap, WRAP_TRAP);

    cmd(0,1,0,0,0,16'h0ABC);
    cmd(0,0,1,0,0,16'h0300); check("pre_rst_call", out, 16'h0300);
    check("pre_rst_sp", sp_depth, 3'd1);
    #2 reset = 1'b1;
    #1;
    check("async_out", out, 16'h0000);
    check("async_sp", sp_depth, 3'd0);
    check("async_flags", {ovf_err, unf_err, trap}, 3'b000);
    @(posedge clk); #1;
    check("rst_hold_cmd", out, 16'h0000);
    reset = 1'b0;
    cmd(0,0,0,0,1,16'h0); check("post_rst_inc", out, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
